// File: rtl/halflife_input_conditioner.sv
// rtl/halflife_input_conditioner.sv - sync, debounce, press pulse, auto-repeat and load capture for the half-life timer
module halflife_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1024,
  parameter int REPEAT_RATE     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       load_raw,
  input  logic [3:0] in_raw,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       load_pulse,
  output logic [3:0] in_held
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TM_W   = $clog2(TM_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  // Bit order of the synchronizer vector: [0]=up, [1]=down, [2]=load, [6:3]=preset value
  logic [6:0]      s1_q, s2_q;
  logic [2:0]      btn;
  logic [2:0]      stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [2:0]      press;

  rep_state_e      rep_state_q [2];
  rep_state_e      rep_state_d [2];
  logic [TM_W-1:0] timer_q [2];
  logic [TM_W-1:0] timer_d [2];
  logic [1:0]      rep_pulse;

  logic            up_pulse_q, up_pulse_d;
  logic            down_pulse_q, down_pulse_d;
  logic            load_pulse_q, load_pulse_d;
  logic [3:0]      in_held_q, in_held_d;

  assign btn = s2_q[2:0];

  // Debounce each button; a press is the edge where the stable level flips 0->1
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      press[i]    = 1'b0;
      if (btn[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = btn[i];
          press[i]    = btn[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Up/down repeat FSMs; the next-cycle stable level is used so a release exits on its own edge
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rep_state_d[j] = rep_state_q[j];
      timer_d[j]     = timer_q[j];
      rep_pulse[j]   = 1'b0;
      case (rep_state_q[j])
        IDLE: begin
          if (press[j]) begin
            rep_pulse[j]   = 1'b1;
            timer_d[j]     = '0;
            rep_state_d[j] = WAIT;
          end
        end
        WAIT: begin
          if (!stable_d[j]) begin
            timer_d[j]     = '0;
            rep_state_d[j] = IDLE;
          end else if (timer_q[j] == DELAY_LAST) begin
            rep_pulse[j]   = 1'b1;
            timer_d[j]     = '0;
            rep_state_d[j] = REPEAT;
          end else begin
            timer_d[j] = timer_q[j] + TM_W'(1);
          end
        end
        REPEAT: begin
          if (!stable_d[j]) begin
            timer_d[j]     = '0;
            rep_state_d[j] = IDLE;
          end else if (timer_q[j] == RATE_LAST) begin
            rep_pulse[j] = 1'b1;
            timer_d[j]   = '0;
          end else begin
            timer_d[j] = timer_q[j] + TM_W'(1);
          end
        end
        default: begin
          timer_d[j]     = '0;
          rep_state_d[j] = IDLE;
        end
      endcase
    end
  end

  // Output arbitration: load wins over up/down, and simultaneous up+down cancel each other
  always_comb begin
    load_pulse_d = press[2];
    up_pulse_d   = rep_pulse[0] & ~rep_pulse[1] & ~press[2];
    down_pulse_d = rep_pulse[1] & ~rep_pulse[0] & ~press[2];
    in_held_d    = press[2] ? s2_q[6:3] : in_held_q;
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      for (int j = 0; j < 2; j++) begin
        rep_state_q[j] <= IDLE;
        timer_q[j]     <= '0;
      end
      up_pulse_q   <= 1'b0;
      down_pulse_q <= 1'b0;
      load_pulse_q <= 1'b0;
      in_held_q    <= '0;
    end else begin
      s1_q         <= {in_raw, load_raw, down_raw, up_raw};
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int j = 0; j < 2; j++) begin
        rep_state_q[j] <= rep_state_d[j];
        timer_q[j]     <= timer_d[j];
      end
      up_pulse_q   <= up_pulse_d;
      down_pulse_q <= down_pulse_d;
      load_pulse_q <= load_pulse_d;
      in_held_q    <= in_held_d;
    end
  end

  assign up_pulse   = up_pulse_q;
  assign down_pulse = down_pulse_q;
  assign load_pulse = load_pulse_q;
  assign in_held    = in_held_q;

endmodule

// File: tb/tb_halflife_input_conditioner.sv
// tb/tb_halflife_input_conditioner.sv - directed vector bench for halflife_input_conditioner
module tb_halflife_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_raw, down_raw, load_raw;
  logic [3:0] in_raw;
  logic       up_pulse, down_pulse, load_pulse;
  logic [3:0] in_held;

  int checks   = 0;
  int failures = 0;

  int up_q[$];
  int down_q[$];
  int load_q[$];

  halflife_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_raw    (up_raw),
    .down_raw  (down_raw),
    .load_raw  (load_raw),
    .in_raw    (in_raw),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .load_pulse(load_pulse),
    .in_held   (in_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       up;
    logic       down;
    logic       load;
    logic [3:0] in;
    int         exp_up;
    int         exp_down;
    int         exp_load;
    logic [3:0] exp_held;
  } vec_t;

  vec_t vecs[7];

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int first_of(input int q[$]);
    if (q.size() == 0) return -1;
    return q[0];
  endfunction

  task automatic check_list(input string name, input int act[$], input int exp[$]);
    check_int({name, " count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      check_int($sformatf("%s pulse#%0d cycle", name, i), act[i], exp[i]);
  endtask

  task automatic clear_caps();
    up_q.delete();
    down_q.delete();
    load_q.delete();
  endtask

  // k-th iteration observes the cycle after edge E(base+k); inputs change at negedges only
  task automatic run_cycles(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (up_pulse)   up_q.push_back(base + k);
      if (down_pulse) down_q.push_back(base + k);
      if (load_pulse) load_q.push_back(base + k);
    end
  endtask

  // Reset for 3 cycles with every raw input high; returns at a negedge with rst still high
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    up_raw   = 1'b1;
    down_raw = 1'b1;
    load_raw = 1'b1;
    in_raw   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check_int({tag, " reset outputs"}, int'({up_pulse, down_pulse, load_pulse, in_held}), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_int({tag, " outputs after reset"}, int'({up_pulse, down_pulse, load_pulse, in_held}), 0);
  endtask

  int exp_list[$];

  initial begin
    rst      = 1'b1;
    up_raw   = 1'b0;
    down_raw = 1'b0;
    load_raw = 1'b0;
    in_raw   = 4'h0;

    vecs[0] = '{"up_only",    1'b1, 1'b0, 1'b0, 4'h0,  5, -1, -1, 4'h0};
    vecs[1] = '{"down_only",  1'b0, 1'b1, 1'b0, 4'h9, -1,  5, -1, 4'h0};
    vecs[2] = '{"load_A",     1'b0, 1'b0, 1'b1, 4'hA, -1, -1,  5, 4'hA};
    vecs[3] = '{"up_load",    1'b1, 1'b0, 1'b1, 4'h5, -1, -1,  5, 4'h5};
    vecs[4] = '{"up_down",    1'b1, 1'b1, 1'b0, 4'hC, -1, -1, -1, 4'h0};
    vecs[5] = '{"down_load",  1'b0, 1'b1, 1'b1, 4'hF, -1, -1,  5, 4'hF};
    vecs[6] = '{"idle",       1'b0, 1'b0, 1'b0, 4'h7, -1, -1, -1, 4'h0};

    // Table: each vector is applied as rst releases and held for 12 cycles
    for (int v = 0; v < 7; v++) begin
      do_reset(vecs[v].name);
      rst      = 1'b0;
      up_raw   = vecs[v].up;
      down_raw = vecs[v].down;
      load_raw = vecs[v].load;
      in_raw   = vecs[v].in;
      clear_caps();
      run_cycles(0, 12);
      check_int({vecs[v].name, " up first"},   first_of(up_q),   vecs[v].exp_up);
      check_int({vecs[v].name, " down first"}, first_of(down_q), vecs[v].exp_down);
      check_int({vecs[v].name, " load first"}, first_of(load_q), vecs[v].exp_load);
      check_int({vecs[v].name, " up count"},   up_q.size(),   (vecs[v].exp_up   >= 0) ? 1 : 0);
      check_int({vecs[v].name, " down count"}, down_q.size(), (vecs[v].exp_down >= 0) ? 1 : 0);
      check_int({vecs[v].name, " load count"}, load_q.size(), (vecs[v].exp_load >= 0) ? 1 : 0);
      check_int({vecs[v].name, " in_held"},    int'(in_held), int'(vecs[v].exp_held));
    end

    // Glitch of 3 cycles is swallowed, then a steady press pulses after E5
    do_reset("glitch");
    rst      = 1'b0;
    up_raw   = 1'b0;
    down_raw = 1'b0;
    load_raw = 1'b0;
    in_raw   = 4'h0;
    run_cycles(0, 4);
    up_raw = 1'b1;
    clear_caps();
    run_cycles(0, 3);
    up_raw = 1'b0;
    run_cycles(3, 12);
    check_int("glitch up count", up_q.size(), 0);
    up_raw = 1'b1;
    clear_caps();
    run_cycles(0, 12);
    exp_list = '{5};
    check_list("steady up", up_q, exp_list);

    // Auto-repeat: down held 40 cycles, then released
    do_reset("repeat");
    rst      = 1'b0;
    up_raw   = 1'b0;
    down_raw = 1'b1;
    load_raw = 1'b0;
    in_raw   = 4'h0;
    clear_caps();
    run_cycles(0, 40);
    down_raw = 1'b0;
    run_cycles(40, 25);
    exp_list = '{5, 13, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43};
    check_list("repeat down", down_q, exp_list);
    check_int("repeat up count", up_q.size(), 0);
    check_int("repeat load count", load_q.size(), 0);

    // Load capture, then in_raw changes without a load press
    do_reset("load_hold");
    rst      = 1'b0;
    up_raw   = 1'b0;
    down_raw = 1'b0;
    load_raw = 1'b1;
    in_raw   = 4'hA;
    clear_caps();
    run_cycles(0, 12);
    exp_list = '{5};
    check_list("load press", load_q, exp_list);
    check_int("load captured", int'(in_held), 'hA);
    load_raw = 1'b0;
    in_raw   = 4'h3;
    clear_caps();
    run_cycles(0, 20);
    check_int("load release count", load_q.size(), 0);
    check_int("in_held kept", int'(in_held), 'hA);

    // Reset mid-repeat while up is still held
    do_reset("midrep");
    rst      = 1'b0;
    up_raw   = 1'b1;
    down_raw = 1'b0;
    load_raw = 1'b0;
    in_raw   = 4'h0;
    clear_caps();
    run_cycles(0, 21);
    exp_list = '{5, 13, 16, 19};
    check_list("midrep before", up_q, exp_list);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_int("midrep reset outputs", int'({up_pulse, down_pulse, load_pulse}), 0);
    rst = 1'b0;
    clear_caps();
    run_cycles(0, 12);
    exp_list = '{5};
    check_list("midrep after", up_q, exp_list);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/halflife_input_conditioner.md
Name: halflife_input_conditioner

Overview:
- Upstream front-end for the half-life timer core. Conditions the raw pad inputs for up, down and load.
- Per input: 2-FF synchronizer, debounce, then a one-cycle pulse on each press.
- up/down add auto-repeat while held.
- On a load press, captures the 4-bit preset value so the timer core sees clean pulses and a stable load value.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronized cycles a level must differ from the debounced state before that state changes. Must be ≥2.
- REPEAT_DELAY, 1024: cycles a debounced up/down must stay held after its first pulse before auto-repeat starts. Must be ≥2.
- REPEAT_RATE, 256: cycles between auto-repeat pulses. Must be ≥2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous reset, active-high.
- up_raw  input  1  raw up button, asynchronous to clk.
- down_raw  input  1  raw down button, asynchronous to clk.
- load_raw  input  1  raw load button, asynchronous to clk.
- in_raw  input  4  raw preset value, asynchronous to clk.
- up_pulse  output  1  one-cycle up request.
- down_pulse  output  1  one-cycle down request.
- load_pulse  output  1  one-cycle load request.
- in_held  output  4  preset value captured at the last load.

Behaviour:
- Reset:
  - rst sampled high clears all synchronizer flops, debounced states, counters and FSMs (FSMs go to IDLE).
  - All outputs read 0 in the cycle after that edge.
  - rst asserted mid-debounce or mid-repeat aborts the operation. No pulse is emitted.
  - A button still held when rst is released must re-debounce from 0 before it can pulse.
- Synchronizer: each of up_raw, down_raw, load_raw and in_raw[3:0] passes through two flops (s1 then s2). Only s2 is used downstream.
- Debounce (per button: stable flop plus counter of width ceil(log2(DEBOUNCE_CYCLES))):
  - When s2 == stable: counter <= 0.
  - When s2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - When s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2 and counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- Press event: rise = stable changing 0→1 on this edge. Release changes stable but emits nothing.
- Latency: raw held high from before edge E0 means the pulse is high for exactly the cycle after edge E(DEBOUNCE_CYCLES+1).
- load:
  - load_pulse is registered and equals the press event.
  - At that same edge, in_held <= in_raw s2 value.
  - in_held holds otherwise.
- up/down repeat FSM (one instance each), states IDLE, WAIT, REPEAT, with a timer counter:
  - IDLE: on press event, emit a pulse, timer <= 0, go to WAIT.
  - WAIT: if stable == 0, go to IDLE. Else if timer == REPEAT_DELAY-1, emit a pulse, timer <= 0, go to REPEAT. Else timer++.
  - REPEAT: if stable == 0, go to IDLE. Else if timer == REPEAT_RATE-1, emit a pulse, timer <= 0. Else timer++.
  - A release returns to IDLE on the same edge and no pulse is emitted on that edge.
- Arbitration, applied at the output register:
  - If load_pulse would be 1, up_pulse and down_pulse are forced to 0 that cycle. Suppressed pulses are lost, not deferred; FSM timers still advance.
  - If up and down would pulse in the same cycle, both are forced to 0.
- Pulses are never longer than 1 cycle. Back-to-back pulses from one FSM are at least 2 cycles apart, guaranteed by the parameter minimums.

Test Plan:
Parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3 for all scenarios.
1. Reset/idle: hold rst 3 cycles with all raw inputs 1, release rst → all outputs 0 in the cycle after reset. First up_pulse appears exactly 6 cycles after the first edge with rst low.
2. Debounce: up_raw high for 3 cycles then low → no up_pulse. Then up_raw high steadily before edge E0 → up_pulse high only in the cycle after E5.
3. Auto-repeat: hold down_raw 40 cycles → first pulse after E5, second 8 cycles later, then every 3 cycles. Release → no further pulses once stable drops.
4. Load capture: in_raw=4'hA, press load_raw → load_pulse for 1 cycle and in_held=4'hA. Change in_raw to 4'h3 with no load → in_held stays 4'hA.
5. Arbitration: press up_raw and load_raw on the same cycle → load_pulse=1, up_pulse=0 that cycle. Press up_raw and down_raw together → neither pulses.
6. Reset mid-repeat: hold up_raw into REPEAT, assert rst 1 cycle while still holding → no pulse until a fresh full debounce completes (6 cycles after rst falls).
